axi4_ram_slave: RTL and testbench
=================================

# axi4_ram_slave

AXI4 (full) slave front-end that converts AXI4 write and read bursts into single-word accesses on the byte-strobed dual-port `RAM` block. It sits directly upstream of `RAM`: it drives the RAM write port (`wr_en`/`wr_addr`/`wr_data`/`w_strb`) and read port (`rd_en`/`rd_addr`) and consumes `rd_data`. Write and read channels run independent FSMs, so one write burst and one read burst may be in flight at the same time.

## Interface
- `DATAWIDTH`, 32, data bus width in bits, multiple of 8; must match `RAM`.
- `ADDRWIDTH`, 6, RAM word-address width; must match `RAM`.
- `IDWIDTH`, 4, AXI ID width.
- Byte address width is `ADDRWIDTH + clog2(DATAWIDTH/8)` (localparam `BADDRWIDTH`).
- One clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `awid`/`awaddr`/`awlen`/`awburst`  in  IDWIDTH/BADDRWIDTH/8/2  write address channel.
- `awvalid` in 1, `awready` out 1  AW handshake.
- `wdata`/`wstrb`/`wlast`  in  DATAWIDTH/DATAWIDTH/8/1  write data channel.
- `wvalid` in 1, `wready` out 1  W handshake.
- `bid`/`bresp`  out  IDWIDTH/2  write response.
- `bvalid` out 1, `bready` in 1  B handshake.
- `arid`/`araddr`/`arlen`/`arburst`  in  IDWIDTH/BADDRWIDTH/8/2  read address channel.
- `arvalid` in 1, `arready` out 1  AR handshake.
- `rid`/`rdata`/`rresp`/`rlast`  out  IDWIDTH/DATAWIDTH/2/1  read data channel.
- `rvalid` out 1, `rready` in 1  R handshake.
- `wr_en`/`wr_addr`/`wr_data`/`w_strb`  out  1/ADDRWIDTH/DATAWIDTH/DATAWIDTH/8  to `RAM` write port.
- `rd_en`/`rd_addr`  out  1/ADDRWIDTH  to `RAM` read port; `rd_data` in DATAWIDTH from `RAM`.

## Operation
- Size is always full bus width; sub-word transfers use `wstrb` only. Word address = `axaddr[BADDRWIDTH-1:clog2(DATAWIDTH/8)]`; low byte-offset bits are ignored.
- Burst types: FIXED (address held), INCR (address +1 per beat, wraps modulo 2^ADDRWIDTH), WRAP and reserved encoding 2'b11 are unsupported.
- Write FSM `W_IDLE -> W_DATA -> W_RESP -> W_IDLE`.
  - `W_IDLE`: `awready=1`; on AW handshake latch id/addr/len/burst, clear beat counter and error flag.
  - `W_DATA`: `wready=1`; `wr_en = wvalid` combinationally, `wr_addr` = current word address, `wr_data=wdata`, `w_strb=wstrb`. For an unsupported burst, `w_strb` is forced to 0; the beat is still accepted.
  - Burst ends on beat `awlen+1`, regardless of `wlast`. Go to `W_RESP`.
  - Sticky error on a `wlast` mismatch (asserted early, or missing on the final beat).
  - `W_RESP`: `bvalid=1`, `bid` = latched id. `bresp` is SLVERR (2'b10) if the burst is unsupported or the error flag is set, else OKAY. On `bready`, return to `W_IDLE`.
- Read FSM `R_IDLE -> R_READ -> R_DATA -> (R_READ | R_IDLE)`.
  - `R_IDLE`: `arready=1`; on AR handshake latch fields.
  - `R_READ`: `rd_en=1` for exactly one cycle at the current address.
  - `R_DATA`: `rvalid=1`, `rdata=rd_data` (RAM output holds because `rd_en=0`), `rid` = latched id, `rlast` = (beat == arlen).
  - `rresp`: SLVERR for an unsupported burst, otherwise OKAY. Unsupported bursts still return `arlen+1` beats of the addressed data.
  - On `rready`: if last, go to `R_IDLE`; else advance the address and go to `R_READ`.
- A read of the word being written in the same cycle returns the old contents.

## Timing
- Reset values:
  - `awready=1`, `arready=1`.
  - `wready=0`, `bvalid=0`, `bresp=0`, `bid=0`.
  - `rvalid=0`, `rresp=0`, `rlast=0`, `rid=0`.
  - `wr_en=0`, `rd_en=0`.
  - `rdata` is don't-care while `rvalid=0`.
- Write throughput: 1 beat/cycle. `bvalid` asserts the cycle after the final W handshake.
- Read: `rvalid` asserts 2 cycles after the AR handshake. Throughput is 1 beat per 2 cycles when `rready` is held high.
- Outputs stay stable while `valid && !ready`.
- Reset mid-burst: both FSMs go to idle next edge. The pending B/R response is dropped. Memory is untouched beyond beats already written.

## Structure
- Package `axi4_pkg`: burst encodings (FIXED/INCR/WRAP), response codes (OKAY/SLVERR), write and read FSM state encodings.
- Sub-module `axi4_burst_addr`: next-word-address computation for burst type and wrap. Instantiated once per channel.
- Top-level `axi4_ram_top` instantiates `axi4_ram_slave` and `RAM`.

## Test plan
- INCR write: AW addr 0x10, len 3, data 0xA0..0xA3, strb 0xF -> words 4..7 written, one `bresp=OKAY`; INCR read of the same range -> 0xA0..0xA3, `rlast` on beat 4 only.
- Strobes: word 0 = 0x11223344, then write 0xAABBCCDD with strb 4'b0101 -> read returns 0x11BB33DD.
- FIXED write at 0x08, len 2, data 1,2,3 -> word 2 = 3. INCR from word 63, len 1 -> words 63 and 0 written.
- WRAP burst write -> no byte changes, `bresp=SLVERR`. Early `wlast` on beat 1 of len 3 -> four beats accepted, `bresp=SLVERR`.
- Backpressure: `rready` and `bready` low for 5 cycles -> `rvalid`/`rdata`/`bvalid` held stable. A concurrent write burst and read burst both complete correctly.
- `rst` asserted in mid-read after beat 2 of 4 -> `rvalid=0` next cycle, `arready=1`, and a new burst completes normally.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM state constants for the RAM slave front-end.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_READ = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // WRAP and the reserved encoding are not handled by this slave.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/RAM.sv
// Byte-strobed simple dual-port RAM with registered read; one memory array per byte lane.
module RAM #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 6
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDRWIDTH-1:0]   wr_addr,
  input  logic [DATAWIDTH-1:0]   wr_data,
  input  logic [DATAWIDTH/8-1:0] w_strb,
  input  logic                   rd_en,
  input  logic [ADDRWIDTH-1:0]   rd_addr,
  output logic [DATAWIDTH-1:0]   rd_data
);

  localparam int LANES = DATAWIDTH / 8;
  localparam int DEPTH = 1 << ADDRWIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      // Read-before-write: a same-cycle read of the written word sees old data.
      always_ff @(posedge clk) begin
        if (wr_en && w_strb[gi]) begin
          mem[wr_addr] <= wr_data[gi*8 +: 8];
        end
        if (rd_en) begin
          q_reg <= mem[rd_addr];
        end
      end

      assign rd_data[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/axi4_burst_addr.sv
// Next word address for one burst beat; INCR wraps naturally at the top of the RAM.
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int ADDRWIDTH = 6
) (
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic [1:0]           burst,
  output logic [ADDRWIDTH-1:0] next_addr
);

  // Anything other than INCR holds the address; unsupported bursts never write anyway.
  always_comb begin
    next_addr = addr;
    if (burst == BURST_INCR) begin
      next_addr = addr + ADDRWIDTH'(1);
    end
  end

endmodule

// File: rtl/axi4_ram_top.sv
// AXI4-accessible RAM: the burst front-end wired to the byte-strobed RAM.
module axi4_ram_top #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 6,
  parameter int IDWIDTH    = 4,
  localparam int BADDRWIDTH = ADDRWIDTH + $clog2(DATAWIDTH / 8)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDWIDTH-1:0]     awid,
  input  logic [BADDRWIDTH-1:0]  awaddr,
  input  logic [7:0]             awlen,
  input  logic [1:0]             awburst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [DATAWIDTH-1:0]   wdata,
  input  logic [DATAWIDTH/8-1:0] wstrb,
  input  logic                   wlast,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [IDWIDTH-1:0]     bid,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [IDWIDTH-1:0]     arid,
  input  logic [BADDRWIDTH-1:0]  araddr,
  input  logic [7:0]             arlen,
  input  logic [1:0]             arburst,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [IDWIDTH-1:0]     rid,
  output logic [DATAWIDTH-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic                   rvalid,
  input  logic                   rready
);

  logic                   wr_en;
  logic [ADDRWIDTH-1:0]   wr_addr;
  logic [DATAWIDTH-1:0]   wr_data;
  logic [DATAWIDTH/8-1:0] w_strb;
  logic                   rd_en;
  logic [ADDRWIDTH-1:0]   rd_addr;
  logic [DATAWIDTH-1:0]   rd_data;

  axi4_ram_slave #(
    .DATAWIDTH(DATAWIDTH), .ADDRWIDTH(ADDRWIDTH), .IDWIDTH(IDWIDTH)
  ) u_slave (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .w_strb(w_strb),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  RAM #(.DATAWIDTH(DATAWIDTH), .ADDRWIDTH(ADDRWIDTH)) u_ram (
    .clk(clk),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .w_strb(w_strb),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

endmodule

// File: rtl/axi4_ram_slave.sv
// AXI4 slave turning write/read bursts into single-word RAM accesses.
// Write and read channels have independent FSMs and may run concurrently.
module axi4_ram_slave
  import axi4_pkg::*;
#(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 6,
  parameter int IDWIDTH    = 4,
  localparam int OFFWIDTH   = $clog2(DATAWIDTH / 8),
  localparam int BADDRWIDTH = ADDRWIDTH + OFFWIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDWIDTH-1:0]     awid,
  input  logic [BADDRWIDTH-1:0]  awaddr,
  input  logic [7:0]             awlen,
  input  logic [1:0]             awburst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [DATAWIDTH-1:0]   wdata,
  input  logic [DATAWIDTH/8-1:0] wstrb,
  input  logic                   wlast,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [IDWIDTH-1:0]     bid,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [IDWIDTH-1:0]     arid,
  input  logic [BADDRWIDTH-1:0]  araddr,
  input  logic [7:0]             arlen,
  input  logic [1:0]             arburst,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [IDWIDTH-1:0]     rid,
  output logic [DATAWIDTH-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic                   rvalid,
  input  logic                   rready,
  output logic                   wr_en,
  output logic [ADDRWIDTH-1:0]   wr_addr,
  output logic [DATAWIDTH-1:0]   wr_data,
  output logic [DATAWIDTH/8-1:0] w_strb,
  output logic                   rd_en,
  output logic [ADDRWIDTH-1:0]   rd_addr,
  input  logic [DATAWIDTH-1:0]   rd_data
);

  logic [1:0]           w_state_reg;
  logic [IDWIDTH-1:0]   w_id_reg;
  logic [ADDRWIDTH-1:0] w_addr_reg;
  logic [ADDRWIDTH-1:0] w_addr_next;
  logic [7:0]           w_len_reg;
  logic [7:0]           w_beat_reg;
  logic [1:0]           w_burst_reg;
  logic                 w_err_reg;
  logic                 w_final;
  logic                 w_ok_burst;

  logic [1:0]           r_state_reg;
  logic [IDWIDTH-1:0]   r_id_reg;
  logic [ADDRWIDTH-1:0] r_addr_reg;
  logic [ADDRWIDTH-1:0] r_addr_next;
  logic [7:0]           r_len_reg;
  logic [7:0]           r_beat_reg;
  logic [1:0]           r_burst_reg;
  logic                 r_final;

  // Byte-offset bits carry no information since every transfer is full width.
  logic addr_unused;
  assign addr_unused = ^{awaddr, araddr};

  axi4_burst_addr #(.ADDRWIDTH(ADDRWIDTH)) u_waddr (
    .addr      (w_addr_reg),
    .burst     (w_burst_reg),
    .next_addr (w_addr_next)
  );

  axi4_burst_addr #(.ADDRWIDTH(ADDRWIDTH)) u_raddr (
    .addr      (r_addr_reg),
    .burst     (r_burst_reg),
    .next_addr (r_addr_next)
  );

  assign w_final    = (w_beat_reg == w_len_reg);
  assign w_ok_burst = burst_supported(w_burst_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      w_id_reg    <= '0;
      w_addr_reg  <= '0;
      w_len_reg   <= '0;
      w_beat_reg  <= '0;
      w_burst_reg <= BURST_FIXED;
      w_err_reg   <= 1'b0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (awvalid) begin
            w_id_reg    <= awid;
            w_addr_reg  <= awaddr[BADDRWIDTH-1 -: ADDRWIDTH];
            w_len_reg   <= awlen;
            w_burst_reg <= awburst;
            w_beat_reg  <= '0;
            w_err_reg   <= 1'b0;
            w_state_reg <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            // The beat count, not wlast, terminates the burst; a mismatch only flags an error.
            if (wlast != w_final) begin
              w_err_reg <= 1'b1;
            end
            if (w_final) begin
              w_state_reg <= W_RESP;
            end else begin
              w_beat_reg <= w_beat_reg + 8'd1;
              w_addr_reg <= w_addr_next;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  assign awready = (w_state_reg == W_IDLE);
  assign wready  = (w_state_reg == W_DATA);
  assign bvalid  = (w_state_reg == W_RESP);
  assign bid     = w_id_reg;
  assign bresp   = (bvalid && (!w_ok_burst || w_err_reg)) ? RESP_SLVERR : RESP_OKAY;

  assign wr_en   = wready && wvalid;
  assign wr_addr = w_addr_reg;
  assign wr_data = wdata;
  assign w_strb  = w_ok_burst ? wstrb : '0;

  assign r_final = (r_beat_reg == r_len_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      r_id_reg    <= '0;
      r_addr_reg  <= '0;
      r_len_reg   <= '0;
      r_beat_reg  <= '0;
      r_burst_reg <= BURST_FIXED;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (arvalid) begin
            r_id_reg    <= arid;
            r_addr_reg  <= araddr[BADDRWIDTH-1 -: ADDRWIDTH];
            r_len_reg   <= arlen;
            r_burst_reg <= arburst;
            r_beat_reg  <= '0;
            r_state_reg <= R_READ;
          end
        end
        R_READ: r_state_reg <= R_DATA;
        R_DATA: begin
          if (rready) begin
            if (r_final) begin
              r_state_reg <= R_IDLE;
            end else begin
              r_beat_reg  <= r_beat_reg + 8'd1;
              r_addr_reg  <= r_addr_next;
              r_state_reg <= R_READ;
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // rdata is taken straight from the RAM register, which holds while rd_en is low.
  assign arready = (r_state_reg == R_IDLE);
  assign rd_en   = (r_state_reg == R_READ);
  assign rd_addr = r_addr_reg;
  assign rvalid  = (r_state_reg == R_DATA);
  assign rdata   = rd_data;
  assign rid     = r_id_reg;
  assign rlast   = rvalid && r_final;
  assign rresp   = (rvalid && !burst_supported(r_burst_reg)) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi4_ram_slave.sv
// Scoreboard bench for axi4_ram_slave: stimulus pushes expected B/R responses, a monitor pops and compares.
module tb_axi4_ram_slave;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, arid, bid, rid;
  logic [7:0]  awaddr, araddr, awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] wdata, rdata, wr_data, rd_data;
  logic [3:0]  wstrb, w_strb;
  logic        wr_en, rd_en;
  logic [5:0]  wr_addr, rd_addr;

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_item_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_item_t;
  b_item_t exp_b[$];
  r_item_t exp_r[$];

  int n_checks = 0;
  int n_fail   = 0;
  int r_pops   = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  always #5 clk = ~clk;

  axi4_ram_slave #(.DATAWIDTH(32), .ADDRWIDTH(6), .IDWIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .w_strb(w_strb),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  RAM #(.DATAWIDTH(32), .ADDRWIDTH(6)) u_ram (
    .clk(clk), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .w_strb(w_strb),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string what);
    n_checks++;
    n_fail++;
    $display("FAIL timeout_%s: handshake not seen within 100 cycles", what);
  endtask

  task automatic exp_rd(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp, input logic last);
    r_item_t it;
    it.id = id; it.data = data; it.resp = resp; it.last = last;
    exp_r.push_back(it);
    $display("expect R id=%0d data=0x%08h resp=%0d last=%0b", id, data, resp, last);
  endtask

  task automatic set_wdata(input logic [31:0] base, input int n, input logic [3:0] strb);
    for (int i = 0; i < n; i++) begin
      wd[i] = base + 32'(i);
      ws[i] = strb;
    end
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int last_at, input logic [1:0] resp);
    b_item_t it;
    int t;
    it.id = id; it.resp = resp;
    exp_b.push_back(it);
    $display("write id=%0d addr=0x%02h len=%0d burst=%0d expect bresp=%0d", id, addr, len, burst, resp);
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!awready && t < 100) begin @(negedge clk); t++; end
    if (!awready) timeout_fail("aw");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at); wvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!wready && t < 100) begin @(negedge clk); t++; end
      if (!wready) timeout_fail("w");
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int t;
    $display("read id=%0d addr=0x%02h len=%0d burst=%0d", id, addr, len, burst);
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < 100) begin @(negedge clk); t++; end
    if (!arready) timeout_fail("ar");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d B and %0d R responses outstanding, expected 0", exp_b.size(), exp_r.size());
      exp_b.delete();
      exp_r.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: compares every B/R handshake against the queues and checks hold-stability under backpressure.
  initial begin
    b_item_t be, b_hold;
    r_item_t re, r_hold;
    logic b_stall = 1'b0;
    logic r_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        b_stall = 1'b0;
        r_stall = 1'b0;
      end else begin
        if (b_stall) begin
          chk("b_hold_valid", bvalid, 1'b1);
          chk("b_hold_id", bid, b_hold.id);
          chk("b_hold_resp", bresp, b_hold.resp);
        end
        b_stall = bvalid && !bready;
        if (b_stall) begin b_hold.id = bid; b_hold.resp = bresp; end
        if (r_stall) begin
          chk("r_hold_valid", rvalid, 1'b1);
          chk("r_hold_data", rdata, r_hold.data);
          chk("r_hold_id", rid, r_hold.id);
          chk("r_hold_last", rlast, r_hold.last);
        end
        r_stall = rvalid && !rready;
        if (r_stall) begin r_hold.id = rid; r_hold.data = rdata; r_hold.last = rlast; r_hold.resp = rresp; end
        if (bvalid && bready) begin
          if (exp_b.size() == 0) chk("b_unexpected", bvalid, 1'b0);
          else begin
            be = exp_b.pop_front();
            $display("B id=%0d resp=%0d", bid, bresp);
            chk("bid", bid, be.id);
            chk("bresp", bresp, be.resp);
          end
        end
        if (rvalid && rready) begin
          if (exp_r.size() == 0) chk("r_unexpected", rvalid, 1'b0);
          else begin
            re = exp_r.pop_front();
            r_pops++;
            $display("R id=%0d data=0x%08h resp=%0d last=%0b", rid, rdata, rresp, rlast);
            chk("rid", rid, re.id);
            chk("rdata", rdata, re.data);
            chk("rresp", rresp, re.resp);
            chk("rlast", rlast, re.last);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int target, t;
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_bid", bid, 4'd0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rid", rid, 4'd0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // INCR write words 4..7, read back
    set_wdata(32'hA0, 4, 4'hF);
    write_burst(4'd1, 8'h10, 8'd3, INCR, 3, OKAY);
    exp_rd(4'd2, 32'hA0, OKAY, 1'b0);
    exp_rd(4'd2, 32'hA1, OKAY, 1'b0);
    exp_rd(4'd2, 32'hA2, OKAY, 1'b0);
    exp_rd(4'd2, 32'hA3, OKAY, 1'b1);
    read_burst(4'd2, 8'h10, 8'd3, INCR);
    drain();

    // Byte strobes (offset bits of the second address are ignored)
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    write_burst(4'd3, 8'h00, 8'd0, INCR, 0, OKAY);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    write_burst(4'd4, 8'h02, 8'd0, INCR, 0, OKAY);
    exp_rd(4'd5, 32'h11BB33DD, OKAY, 1'b1);
    read_burst(4'd5, 8'h00, 8'd0, INCR);
    drain();

    // FIXED burst keeps the last beat
    set_wdata(32'd1, 3, 4'hF);
    write_burst(4'd6, 8'h08, 8'd2, FIXED, 2, OKAY);
    exp_rd(4'd7, 32'd3, OKAY, 1'b1);
    read_burst(4'd7, 8'h08, 8'd0, INCR);
    drain();

    // INCR wrap from word 63 to word 0, for both write and read
    set_wdata(32'h63, 2, 4'hF);
    write_burst(4'd8, 8'hFC, 8'd1, INCR, 1, OKAY);
    exp_rd(4'd9, 32'h63, OKAY, 1'b0);
    exp_rd(4'd9, 32'h64, OKAY, 1'b1);
    read_burst(4'd9, 8'hFC, 8'd1, INCR);
    drain();

    // WRAP write leaves memory untouched; WRAP read returns data with SLVERR
    set_wdata(32'hFFFFFFF0, 4, 4'hF);
    write_burst(4'd10, 8'h10, 8'd3, WRAP, 3, SLVERR);
    exp_rd(4'd11, 32'hA0, OKAY, 1'b0);
    exp_rd(4'd11, 32'hA1, OKAY, 1'b0);
    exp_rd(4'd11, 32'hA2, OKAY, 1'b0);
    exp_rd(4'd11, 32'hA3, OKAY, 1'b1);
    read_burst(4'd11, 8'h10, 8'd3, INCR);
    exp_rd(4'd12, 32'hA1, SLVERR, 1'b1);
    read_burst(4'd12, 8'h14, 8'd0, WRAP);
    drain();

    // Early wlast: all four beats still written, SLVERR; missing wlast also SLVERR
    set_wdata(32'hB0, 4, 4'hF);
    write_burst(4'd13, 8'h40, 8'd3, INCR, 1, SLVERR);
    exp_rd(4'd14, 32'hB0, OKAY, 1'b0);
    exp_rd(4'd14, 32'hB1, OKAY, 1'b0);
    exp_rd(4'd14, 32'hB2, OKAY, 1'b0);
    exp_rd(4'd14, 32'hB3, OKAY, 1'b1);
    read_burst(4'd14, 8'h40, 8'd3, INCR);
    set_wdata(32'hC0, 2, 4'hF);
    write_burst(4'd15, 8'h50, 8'd1, INCR, -1, SLVERR);
    drain();

    // Backpressure on B and R
    bready = 1'b0;
    rready = 1'b0;
    set_wdata(32'hD0, 1, 4'hF);
    exp_rd(4'd2, 32'hB0, OKAY, 1'b1);
    fork
      write_burst(4'd1, 8'h60, 8'd0, INCR, 0, OKAY);
      read_burst(4'd2, 8'h40, 8'd0, INCR);
    join
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    bready = 1'b1;
    rready = 1'b1;
    drain();

    // Concurrent write burst and read burst
    set_wdata(32'hE0, 4, 4'hF);
    exp_rd(4'd4, 32'hA0, OKAY, 1'b0);
    exp_rd(4'd4, 32'hA1, OKAY, 1'b0);
    exp_rd(4'd4, 32'hA2, OKAY, 1'b0);
    exp_rd(4'd4, 32'hA3, OKAY, 1'b1);
    fork
      write_burst(4'd3, 8'h50, 8'd3, INCR, 3, OKAY);
      read_burst(4'd4, 8'h10, 8'd3, INCR);
    join
    drain();
    exp_rd(4'd5, 32'hE0, OKAY, 1'b0);
    exp_rd(4'd5, 32'hE1, OKAY, 1'b0);
    exp_rd(4'd5, 32'hE2, OKAY, 1'b0);
    exp_rd(4'd5, 32'hE3, OKAY, 1'b1);
    read_burst(4'd5, 8'h50, 8'd3, INCR);
    drain();

    // Reset after beat 2 of a 4-beat read
    target = r_pops + 2;
    exp_rd(4'd6, 32'hA0, OKAY, 1'b0);
    exp_rd(4'd6, 32'hA1, OKAY, 1'b0);
    read_burst(4'd6, 8'h10, 8'd3, INCR);
    t = 0;
    while (r_pops < target && t < 100) begin @(negedge clk); t++; end
    if (r_pops < target) timeout_fail("r_beats");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_arready", arready, 1'b1);
    chk("mid_rst_pending", 32'(exp_r.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd(4'd7, 32'hA0, OKAY, 1'b0);
    exp_rd(4'd7, 32'hA1, OKAY, 1'b1);
    read_burst(4'd7, 8'h10, 8'd1, INCR);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
